jtframe_neptuno_db9: RTL and testbench

//  Scans both DB9 ports of the Neptuno/MC2 board by driving the shared SELECT pin and decoding

---
 rtl/jtframe_neptuno_db9_pkg.sv | 64 ++++++
 rtl/jtframe_neptuno_db9_port.sv | 100 ++++++++++
 rtl/jtframe_neptuno_db9.sv | 93 +++++++++
 tb/tb_jtframe_neptuno_db9.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_neptuno_db9_pkg.sv
// Shared constants for the Neptuno/MC2 DB9 scanner: FSM codes, joy bit positions, pin indices.
// JTFRAME_DB9_SIXBTN_EN selects the 8-phase (6-button) frame instead of the 4-phase one.
package jtframe_neptuno_db9_pkg;

  localparam int unsigned JOY_W = 12;
  localparam int unsigned BUS_W = 6;
  localparam int unsigned ST_W  = 4;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_P0   = 4'd1;
  localparam logic [3:0] ST_P1   = 4'd2;
  localparam logic [3:0] ST_P2   = 4'd3;
  localparam logic [3:0] ST_P3   = 4'd4;
  localparam logic [3:0] ST_P4   = 4'd5;
  localparam logic [3:0] ST_P5   = 4'd6;
  localparam logic [3:0] ST_P6   = 4'd7;
  localparam logic [3:0] ST_P7   = 4'd8;

`ifdef JTFRAME_DB9_SIXBTN_EN
  localparam logic [3:0] ST_LAST = ST_P7;
`else
  localparam logic [3:0] ST_LAST = ST_P3;
`endif

  localparam int unsigned JB_R     = 0;
  localparam int unsigned JB_L     = 1;
  localparam int unsigned JB_D     = 2;
  localparam int unsigned JB_U     = 3;
  localparam int unsigned JB_A     = 4;
  localparam int unsigned JB_X     = 5;
  localparam int unsigned JB_C     = 6;
  localparam int unsigned JB_B     = 7;
  localparam int unsigned JB_Y     = 8;
  localparam int unsigned JB_Z     = 9;
  localparam int unsigned JB_START = 10;
  localparam int unsigned JB_MODE  = 11;

  localparam int unsigned PIN_U  = 0;
  localparam int unsigned PIN_D  = 1;
  localparam int unsigned PIN_L  = 2;
  localparam int unsigned PIN_R  = 3;
  localparam int unsigned PIN_TL = 4;
  localparam int unsigned PIN_TR = 5;

  // Per-port staging, all fields active-high; dir follows pin order U,D,L,R
  typedef struct packed {
    logic [3:0] dir;
    logic       tl;
    logic       tr;
    logic       a;
    logic       start;
    logic       md;
`ifdef JTFRAME_DB9_SIXBTN_EN
    logic       six;
    logic [3:0] xyzm;
`endif
  } db9_stage_t;

  // SELECT is low in the even-numbered phases (odd state codes)
  function automatic logic db9_sel(input logic [3:0] st);
    return ~st[0];
  endfunction

endpackage

// File: rtl/jtframe_neptuno_db9_port.sv
// One DB9 port: input synchroniser, per-phase sampling into staging, MD/6-button detection.
// Optional 6-button decode under JTFRAME_DB9_SIXBTN_EN.
module jtframe_neptuno_db9_port
  import jtframe_neptuno_db9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] bus,
  input  logic [ST_W-1:0]  state,
  input  logic             tick,
  input  logic             commit,
  output logic [JOY_W-1:0] joy,
  output logic             md,
  output logic             six
);

  logic [BUS_W-1:0] sync1, sync2;
  logic [BUS_W-1:0] pin_c;
  logic [JOY_W-1:0] joy_c;
  db9_stage_t       stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus;
      sync2 <= sync1;
    end
  end

  assign pin_c = ~sync2;

  // Each phase is sampled on the tick that ends it
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else if (tick) begin
      case (state)
        ST_P1: begin
          stg.dir <= pin_c[3:0];
          stg.tl  <= pin_c[PIN_TL];
          stg.tr  <= pin_c[PIN_TR];
        end
        ST_P2: begin
          stg.a     <= pin_c[PIN_TL];
          stg.start <= pin_c[PIN_TR];
          stg.md    <= pin_c[PIN_L] & pin_c[PIN_R];
        end
`ifdef JTFRAME_DB9_SIXBTN_EN
        ST_P4: stg.six <= stg.md & (&pin_c[3:0]);
        ST_P5: if (stg.six) stg.xyzm <= pin_c[3:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    joy_c       = '0;
    joy_c[JB_U] = stg.dir[PIN_U];
    joy_c[JB_D] = stg.dir[PIN_D];
    joy_c[JB_L] = stg.dir[PIN_L];
    joy_c[JB_R] = stg.dir[PIN_R];
    if (stg.md) begin
      joy_c[JB_A]     = stg.a;
      joy_c[JB_B]     = stg.tl;
      joy_c[JB_C]     = stg.tr;
      joy_c[JB_START] = stg.start;
`ifdef JTFRAME_DB9_SIXBTN_EN
      if (stg.six) begin
        joy_c[JB_Z]    = stg.xyzm[0];
        joy_c[JB_Y]    = stg.xyzm[1];
        joy_c[JB_X]    = stg.xyzm[2];
        joy_c[JB_MODE] = stg.xyzm[3];
      end
`endif
    end else begin
      joy_c[JB_A] = stg.tl;
      joy_c[JB_B] = stg.tr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      joy <= '0;
      md  <= 1'b0;
      six <= 1'b0;
    end else if (commit) begin
      joy <= joy_c;
      md  <= stg.md;
`ifdef JTFRAME_DB9_SIXBTN_EN
      six <= stg.six;
`else
      six <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/jtframe_neptuno_db9.sv
// Neptuno/MC2 dual DB9 scanner: prescaler, SELECT phase FSM and frame commit for both ports.
// Define JTFRAME_DB9_SIXBTN_EN for the 8-phase frame with 6-button pad decode.
module jtframe_neptuno_db9 #(
  parameter int unsigned PHASE_TICKS = 960,
  parameter int unsigned IDLE_PHASES = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  joy1_bus,
  input  logic [5:0]  joy2_bus,
  output logic        joy_select,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic        md1,
  output logic        md2,
  output logic        six1,
  output logic        six2,
  output logic        frame_done
);
  import jtframe_neptuno_db9_pkg::*;

  localparam int unsigned PW = $clog2(PHASE_TICKS);
  localparam int unsigned IW = $clog2(IDLE_PHASES + 1);

  logic [PW-1:0]   cnt;
  logic [IW-1:0]   idle_cnt, idle_nxt;
  logic [ST_W-1:0] state, state_nxt;
  logic            tick_c, commit_c;

  assign tick_c   = (cnt == '0);
  assign commit_c = tick_c && (state == ST_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= PW'(PHASE_TICKS - 1);
      state      <= ST_IDLE;
      idle_cnt   <= IW'(IDLE_PHASES);
      joy_select <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick_c ? PW'(PHASE_TICKS - 1) : cnt - PW'(1);
      state      <= state_nxt;
      idle_cnt   <= idle_nxt;
      joy_select <= db9_sel(state_nxt);
      frame_done <= commit_c;
    end
  end

  // Phase sequencing: IDLE holds SELECT high for IDLE_PHASES ticks, then P0..ST_LAST
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    if (tick_c) begin
      case (state)
        ST_IDLE: begin
          if (idle_cnt <= IW'(1)) begin
            state_nxt = ST_P0;
            idle_nxt  = IW'(IDLE_PHASES);
          end else begin
            idle_nxt = idle_cnt - IW'(1);
          end
        end
        ST_LAST: state_nxt = ST_IDLE;
        default: state_nxt = ST_W'(state + ST_W'(1));
      endcase
    end
  end

  jtframe_neptuno_db9_port u_port1 (
    .clk    (clk),
    .rst    (rst),
    .bus    (joy1_bus),
    .state  (state),
    .tick   (tick_c),
    .commit (commit_c),
    .joy    (joy1),
    .md     (md1),
    .six    (six1)
  );

  jtframe_neptuno_db9_port u_port2 (
    .clk    (clk),
    .rst    (rst),
    .bus    (joy2_bus),
    .state  (state),
    .tick   (tick_c),
    .commit (commit_c),
    .joy    (joy2),
    .md     (md2),
    .six    (six2)
  );

endmodule

// File: tb/tb_jtframe_neptuno_db9.sv
// Bench for jtframe_neptuno_db9: pad BFMs (none/Atari/MD3/MD6) driven by SELECT, checked per frame
// against a button-level model. Honours JTFRAME_DB9_SIXBTN_EN.
module tb_jtframe_neptuno_db9;

  localparam int unsigned PT = 4;
  localparam int unsigned IP = 2;
`ifdef JTFRAME_DB9_SIXBTN_EN
  localparam bit SIX = 1'b1;
  localparam int NPH = 8;
`else
  localparam bit SIX = 1'b0;
  localparam int NPH = 4;
`endif
  localparam int IDLE_CLKS = IP * PT;
  localparam logic [11:0] ATARI_MASK = 12'h09F;
  localparam logic [11:0] MD3_MASK   = 12'h4DF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  joy1_bus, joy2_bus;
  logic        joy_select;
  logic [11:0] joy1, joy2;
  logic        md1, md2, six1, six2, frame_done;

  int          pt1 = 0, pt2 = 0;
  logic [11:0] pb1 = '0, pb2 = '0;
  int          sel_edges = 0;
  int          hi_cnt = 0;
  logic        prev_sel = 1'b1;
  logic [13:0] cur1 = '0, cur2 = '0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  jtframe_neptuno_db9 #(.PHASE_TICKS(PT), .IDLE_PHASES(IP)) dut (
    .clk        (clk),
    .rst        (rst),
    .joy1_bus   (joy1_bus),
    .joy2_bus   (joy2_bus),
    .joy_select (joy_select),
    .joy1       (joy1),
    .joy2       (joy2),
    .md1        (md1),
    .md2        (md2),
    .six1       (six1),
    .six2       (six2),
    .frame_done (frame_done)
  );

  // Pad-side SELECT transition counter; long SELECT-high resets it as a real 6-button pad does
  always @(posedge clk) begin
    prev_sel <= joy_select;
    if (joy_select != prev_sel) begin
      sel_edges <= sel_edges + 1;
      hi_cnt    <= 0;
    end else if (joy_select) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt >= 5) sel_edges <= 0;
    end
  end

  // Pin levels for a pad type: 0 none, 1 Atari, 2 MD 3-button, 3 MD 6-button. b uses joy layout.
  function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b, input logic sel,
                                          input int e);
    logic [5:0] a;
    case (t)
      0: a = 6'b0;
      1: a = {b[7], b[4], b[0], b[1], b[2], b[3]};
      default: begin
        if (t == 3 && !sel && e == 5)      a = {b[10], b[4], 4'b1111};
        else if (t == 3 && sel && e == 6)  a = {b[6], b[7], b[11], b[5], b[8], b[9]};
        else if (t == 3 && !sel && e == 7) a = {b[10], b[4], 4'b0000};
        else if (sel)                      a = {b[6], b[7], b[0], b[1], b[2], b[3]};
        else                               a = {b[10], b[4], 2'b11, b[2], b[3]};
      end
    endcase
    return ~a;
  endfunction

  assign joy1_bus = pad_pins(pt1, pb1, joy_select, sel_edges);
  assign joy2_bus = pad_pins(pt2, pb2, joy_select, sel_edges);

  // Expected {six, md, joy} after a frame with pad type t holding buttons b
  function automatic logic [13:0] model(input int t, input logic [11:0] b);
    case (t)
      0:       return 14'h0;
      1:       return {2'b00, b & ATARI_MASK};
      2:       return {2'b01, b & MD3_MASK};
      default: return SIX ? {2'b11, b} : {2'b01, b & MD3_MASK};
    endcase
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3]) b[2] = 1'b0;
    if (b[0]) b[1] = 1'b0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_pads(input int t1, input logic [11:0] b1, input int t2,
                          input logic [11:0] b2);
    pt1 = t1; pb1 = b1; pt2 = t2; pb2 = b2;
  endtask

  // Waits for the next commit, checking outputs hold until then and the pulse is one clk wide
  task automatic wait_frame(input logic [13:0] e1, input logic [13:0] e2);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        chk("port1", 32'({six1, md1, joy1}), 32'(e1));
        chk("port2", 32'({six2, md2, joy2}), 32'(e2));
        cur1 = e1;
        cur2 = e2;
        done = 1'b1;
      end else begin
        chk("hold1", 32'({six1, md1, joy1}), 32'(cur1));
        chk("hold2", 32'({six2, md2, joy2}), 32'(cur2));
      end
    end
    if (!done) begin
      chk("frame_timeout", 32'(0), 32'(1));
    end else begin
      @(posedge clk); #1;
      chk("fd_width", 32'(frame_done), 32'(0));
    end
  endtask

  // Waits for the n-th transition of SELECT to level lvl
  task automatic wait_sel(input logic lvl, input int n);
    int   seen = 0;
    logic p = joy_select;
    for (int i = 0; i < 500 && seen < n; i++) begin
      @(posedge clk); #1;
      if (joy_select == lvl && p != lvl) seen++;
      p = joy_select;
    end
    if (seen < n) chk("sel_timeout", 32'(seen), 32'(n));
  endtask

  initial begin
    int t1, t2;
    logic [11:0] b1, b2;
    logic exp_sel;

    set_pads(0, '0, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(joy_select), 32'(1));
    chk("rst_out", 32'({six2, md2, joy2, six1, md1, joy1, frame_done}), 32'(0));
    rst = 1'b0;

    // First frame with nothing plugged: SELECT timing and empty commit
    for (int k = 1; k <= IDLE_CLKS + 4 * NPH + 1; k++) begin
      @(posedge clk); #1;
      if (k < IDLE_CLKS || k >= IDLE_CLKS + 4 * NPH) exp_sel = 1'b1;
      else exp_sel = (((k - IDLE_CLKS) / 4) % 2) == 1;
      chk("sel_seq", 32'(joy_select), 32'(exp_sel));
      chk("fd_seq", 32'(frame_done), 32'(k == IDLE_CLKS + 4 * NPH));
      if (k == IDLE_CLKS + 4 * NPH)
        chk("empty", 32'({six2, md2, joy2, six1, md1, joy1}), 32'(0));
    end

    set_pads(2, 12'h440, 0, '0);
    wait_frame(model(2, 12'h440), model(0, '0));
    set_pads(2, 12'h440, 3, 12'h828);
    wait_frame(model(2, 12'h440), model(3, 12'h828));
    set_pads(1, 12'h011, 3, 12'h828);
    wait_frame(model(1, 12'h011), model(3, 12'h828));

    // Button change during P3 lands only in the following frame
    set_pads(2, 12'h010, 1, 12'h080);
    wait_sel(1'b1, 2);
    pb1 = 12'h408;
    wait_frame(model(2, 12'h010), model(1, 12'h080));
    wait_frame(model(2, 12'h408), model(1, 12'h080));

    // Reset in the middle of a frame
    set_pads(2, 12'h440, 3, 12'h828);
    wait_frame(model(2, 12'h440), model(3, 12'h828));
    wait_sel(1'b0, SIX ? 3 : 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sel", 32'(joy_select), 32'(1));
    chk("mid_rst_out", 32'({six2, md2, joy2, six1, md1, joy1, frame_done}), 32'(0));
    rst = 1'b0;
    cur1 = '0;
    cur2 = '0;
    wait_frame(model(2, 12'h440), model(3, 12'h828));

    for (int n = 0; n < 30; n++) begin
      t1 = int'($urandom_range(0, 3));
      t2 = int'($urandom_range(0, 3));
      b1 = rand_btn();
      b2 = rand_btn();
      set_pads(t1, b1, t2, b2);
      wait_frame(model(t1, b1), model(t2, b2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
